// File: rtl/dnn_pkg.sv
// Shared types and width helpers for the dnn inference blocks.
package dnn_pkg;

    // Frame sequencer states: collecting beats, or presenting a result
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width of a beat counter covering num_classes/n beats (at least 1 bit)
    function automatic int unsigned beat_cnt_w(input int unsigned num_classes,
                                               input int unsigned n);
        int unsigned beats;
        beats = num_classes / n;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Width of a class index covering num_classes classes (at least 1 bit)
    function automatic int unsigned idx_w(input int unsigned num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

endpackage

// File: rtl/max_finder_set.sv
// Combinational max/position finder over N packed unsigned values.
// Ties resolve to the lowest position.
module max_finder_set #(
    parameter  int unsigned width = 4,
    parameter  int unsigned N     = 4,
    localparam int unsigned POS_W = $clog2(N)
) (
    input  logic [width*N-1:0] in_data,
    output logic [width-1:0]   max_val,
    output logic [POS_W-1:0]   max_pos
);

    // Linear scan; strict compare keeps the earliest position on a tie
    always_comb begin
        max_val = in_data[width-1:0];
        max_pos = '0;
        for (int unsigned k = 1; k < N; k++) begin
            if (in_data[width*k +: width] > max_val) begin
                max_val = in_data[width*k +: width];
                max_pos = POS_W'(k);
            end
        end
    end

endmodule

// File: rtl/argmax_sequencer.sv
// Streaming argmax over a frame of NUM_CLASSES values delivered N per beat.
// Optional scoring against a per-frame label: define ARGMAX_SEQUENCER_SCORE_EN.
module argmax_sequencer
    import dnn_pkg::*;
#(
    parameter  int unsigned width       = 4,
    parameter  int unsigned N           = 4,
    parameter  int unsigned NUM_CLASSES = 32,
    localparam int unsigned IDX_W       = idx_w(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width*N-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width-1:0]   out_max,
`ifdef ARGMAX_SEQUENCER_SCORE_EN
    input  logic [IDX_W-1:0]   label,
    output logic               correct,
    output logic [15:0]        hit_count,
`endif
    output logic [IDX_W-1:0]   out_idx
);

    localparam int unsigned CNT_W = beat_cnt_w(NUM_CLASSES, N);
    localparam int unsigned POS_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CLASSES / N - 1);

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [width-1:0]   run_max;
    logic [IDX_W-1:0]   run_idx;

    logic [width-1:0]   chunk_max;
    logic [POS_W-1:0]   chunk_pos;
    logic [IDX_W-1:0]   cand_idx;
    logic               accept;

    max_finder_set #(
        .width (width),
        .N     (N)
    ) u_chunk (
        .in_data (in_data),
        .max_val (chunk_max),
        .max_pos (chunk_pos)
    );

    assign accept   = in_valid && in_ready;
    assign cand_idx = IDX_W'(beat_cnt) * IDX_W'(N) + IDX_W'(chunk_pos);
    assign out_max  = run_max;
    assign out_idx  = run_idx;

    // Frame FSM: accumulate running max over beats, then hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            beat_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            run_max   <= '0;
            run_idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (beat_cnt == '0 || chunk_max > run_max) begin
                            run_max <= chunk_max;
                            run_idx <= cand_idx;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt  <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef ARGMAX_SEQUENCER_SCORE_EN
    logic [IDX_W-1:0] label_q;

    assign correct = (state == HOLD) && (run_idx == label_q);

    // Capture the frame label alongside the first beat of each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label_q <= '0;
        end else if (accept && beat_cnt == '0) begin
            label_q <= label;
        end
    end

    // Count correctly classified frames as they are handed off, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (out_valid && out_ready && correct && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule
